obstacle_generator: RTL and testbench
=====================================

# obstacle_generator

Pseudo-random obstacle source and scroller for the dino game. It holds an 8-cell obstacle track, injects new obstacles at the far end under LFSR control with enforced spacing, and shifts the track one cell toward the player on each scroll step. The track drives the LED row directly; the player/collision logic samples `ledLine[0]`.

## Interface
- `WIDTH`, 8: number of track cells.
- `SCROLL_DIV`, 1: clock cycles per scroll step; legal range ≥1.
- `LFSR_SEED`, 8'hB8: LFSR reset value; must be nonzero.
- `MIN_GAP`, 2: minimum number of empty cells between consecutive obstacles.
- `MAX_GAP`, 6: a gap of this many empty cells forces a spawn; must be > `MIN_GAP`.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `ledLine`  output  `WIDTH`: obstacle track, registered.
  - Bit `WIDTH-1` is the spawn cell.
  - Bit 0 is the player cell.
  - 1 means an obstacle is present.

## Operation
- **Internal state:**
  - scroll divider `div`: 0..`SCROLL_DIV-1`
  - 8-bit Fibonacci LFSR `lfsr`
  - gap counter `gap`: 0..`MAX_GAP`, saturating
  - track register driving `ledLine`
- **Step tick:** `step` is asserted in a cycle when `div == SCROLL_DIV-1`.
  - On `step`: `div` returns to 0.
  - Otherwise: `div` increments.
  - With `SCROLL_DIV=1`, every cycle is a step.
- **Spawn decision:** evaluated only on `step`, using the current (pre-advance) `lfsr` and `gap`.
  - `spawn = (gap >= MIN_GAP) && ((lfsr[1:0] == 2'b11) || (gap == MAX_GAP))`
- **On `step`, all updates are simultaneous:**
  - `ledLine <= {spawn, ledLine[WIDTH-1:1]}`. Bit 0 shifts out and is discarded.
  - `gap <= spawn ? 0 : min(gap+1, MAX_GAP)`.
  - `lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}`.
- **No `step`:** `ledLine`, `lfsr` and `gap` hold.
- **Guarantees:**
  - Two obstacles never sit closer than `MIN_GAP` empty cells apart.
  - A run of empty cells never exceeds `MAX_GAP`.
  - The LFSR never reaches zero from a nonzero seed.

## Timing
- **Reset values (asserted asynchronously, immediately):**
  - `ledLine = 0`
  - `lfsr = LFSR_SEED`
  - `gap = 0`
  - `div = 0`
- **Reset release:** the first step occurs on the `SCROLL_DIV`-th rising edge after reset deasserts.
- **Latency:** a spawned obstacle appears at `ledLine[WIDTH-1]` on the same edge as the spawn decision. It reaches `ledLine[0]` `WIDTH-1` steps later and leaves on the following step.
- **Reset mid-operation:** reset asserted at any time clears the track and restarts the sequence exactly as from power-up. The post-reset spawn pattern is fully deterministic.
- **First obstacle with defaults:** the earliest possible first obstacle is on step 3, because `gap` must reach `MIN_GAP`.
  - Steps 1–5 (LFSR values B8, 70, E0, C0, 81) produce no spawn.
  - Step 6 (LFSR 03) spawns.
- **Boundary cases:**
  - Simultaneous spawn and shift-out of bit 0 are independent.
  - A forced spawn at `gap == MAX_GAP` ignores the LFSR.
  - `gap` saturates and does not wrap.

## Test plan
- Assert reset for several cycles with defaults, then release → `ledLine = 8'h00` during reset. `ledLine` stays 0 for the first 5 clocks after release. After the 6th clock `ledLine = 8'h80`. After the 7th clock `ledLine = 8'h40`.
- Run 400 cycles with defaults, checking every cycle:
  - each clock, `ledLine[6:0]` equals the previous `ledLine[7:1]`;
  - any two set bits are at least 3 positions apart (gap ≥ 2 empty cells);
  - no more than 6 consecutive steps occur without a spawn.
- Assert reset mid-run while `ledLine` is nonzero → `ledLine` is 0 immediately without a clock edge. After release, the output sequence reproduces the power-up sequence cycle for cycle.
- Set `SCROLL_DIV=4` → `ledLine` changes only on every 4th clock. The first `8'h80` appears after clock 24 post-reset.
- Set `LFSR_SEED = 8'h03` and `MIN_GAP=2` → no spawn on steps 1–2 even though `lfsr[1:0]=11` at step 1. `gap` gating holds.
- Run a long simulation (100k steps) → `lfsr` never equals 0. The obstacle density lies between 1/7 and 1/3 of steps.

Source files
------------

// File: rtl/obstacle_generator_if.sv
// Obstacle track bus: the registered LED row produced by the generator.
interface obstacle_generator_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] ledLine;

  modport master (output ledLine);
  modport slave  (input  ledLine);
endinterface

// File: rtl/obstacle_generator.sv
// LFSR-driven obstacle spawner with enforced spacing, scrolling an obstacle
// track toward the player cell (bit 0) once per scroll step.

module obstacle_cell (
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q <= 1'b0;
    else if (step) q <= d;
  end
endmodule

module obstacle_generator #(
  parameter int         WIDTH      = 8,
  parameter int         SCROLL_DIV = 1,
  parameter logic [7:0] LFSR_SEED  = 8'hB8,
  parameter int         MIN_GAP    = 2,
  parameter int         MAX_GAP    = 6
) (
  input  logic clk,
  input  logic reset,
  obstacle_generator_if.master track
);
  localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int GAP_W = $clog2(MAX_GAP + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
  localparam logic [GAP_W-1:0] MIN_G    = GAP_W'(MIN_GAP);
  localparam logic [GAP_W-1:0] MAX_G    = GAP_W'(MAX_GAP);

  logic [DIV_W-1:0] div;
  logic [7:0]       lfsr;
  logic [GAP_W-1:0] gap;
  logic [GAP_W-1:0] gap_nxt;
  logic [WIDTH-1:0] line;
  logic             step;
  logic             spawn;

  assign step = (div == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div <= '0;
    else if (step) div <= '0;
    else           div <= div + 1'b1;
  end

  // Forced spawn at MAX_GAP overrides the LFSR; MIN_GAP gating overrides both.
  assign spawn = (gap >= MIN_G) && ((lfsr[1:0] == 2'b11) || (gap == MAX_G));

  always_comb begin
    gap_nxt = gap;
    if (spawn)             gap_nxt = '0;
    else if (gap != MAX_G) gap_nxt = gap + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
      gap  <= '0;
    end else if (step) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      gap  <= gap_nxt;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic d;
    if (i == WIDTH - 1) begin : g_spawn
      assign d = spawn;
    end else begin : g_shift
      assign d = line[i+1];
    end
    obstacle_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .step  (step),
      .d     (d),
      .q     (line[i])
    );
  end

  assign track.ledLine = line;
endmodule

// File: tb/tb_obstacle_generator.sv
// Directed bench for obstacle_generator: power-up sequence, track invariants,
// async mid-run reset with replay, slow scroll and alternate seed variants.
module tb_obstacle_generator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  obstacle_generator_if #(.WIDTH(8)) bus1 ();
  obstacle_generator_if #(.WIDTH(8)) bus4 ();
  obstacle_generator_if #(.WIDTH(8)) bus3 ();

  obstacle_generator dut1 (.clk(clk), .reset(rst), .track(bus1));
  obstacle_generator #(.SCROLL_DIV(4)) dut4 (.clk(clk), .reset(rst), .track(bus4));
  obstacle_generator #(.LFSR_SEED(8'h03)) dut3 (.clk(clk), .reset(rst), .track(bus3));

  logic [7:0] rec [0:400];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] cur;
    logic       bad;
    int         zrun;
    int         spawns;
    int         waits;

    // Power-up reset
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_dut1", 32'(bus1.ledLine), 32'h00);
    chk("reset_dut4", 32'(bus4.ledLine), 32'h00);
    chk("reset_dut3", 32'(bus3.ledLine), 32'h00);

    rst    = 1'b0;
    prev   = 8'h00;
    zrun   = 0;
    spawns = 0;
    rec[0] = 8'h00;
    for (int c = 1; c <= 400; c++) begin
      tick();
      cur    = bus1.ledLine;
      rec[c] = cur;

      if (c <= 5) chk($sformatf("pwrup_zero_c%0d", c), 32'(cur), 32'h00);
      if (c == 6) chk("pwrup_first_spawn", 32'(cur), 32'h80);
      if (c == 7) chk("pwrup_shift", 32'(cur), 32'h40);

      // Seed 03: lfsr[1:0]=11 at step 1 is gated; forced spawn at step 7.
      if (c <= 6) chk($sformatf("seed03_zero_c%0d", c), 32'(bus3.ledLine), 32'h00);
      if (c == 7) chk("seed03_forced_spawn", 32'(bus3.ledLine), 32'h80);

      if (c < 24) chk($sformatf("div4_zero_c%0d", c), 32'(bus4.ledLine), 32'h00);
      if (c >= 24 && c <= 27) chk($sformatf("div4_hold_c%0d", c), 32'(bus4.ledLine), 32'h80);
      if (c == 28) chk("div4_shift", 32'(bus4.ledLine), 32'h40);

      chk($sformatf("shift_c%0d", c), 32'(cur[6:0]), 32'(prev[7:1]));

      bad = 1'b0;
      for (int i = 0; i < 7; i++) begin
        if (cur[i] && cur[i+1]) bad = 1'b1;
        if (i < 6 && cur[i] && cur[i+2]) bad = 1'b1;
      end
      chk($sformatf("spacing_c%0d", c), 32'(bad), 32'h0);

      if (cur[7]) begin
        zrun = 0;
        spawns++;
      end else begin
        zrun++;
      end
      chk($sformatf("maxgap_c%0d", c), 32'(zrun <= 6), 32'h1);
      prev = cur;
    end

    chk("density_low",  32'(spawns * 7 >= 393), 32'h1);
    chk("density_high", 32'(spawns * 3 <= 403), 32'h1);

    // Mid-run async reset while the track is occupied
    waits = 0;
    while (bus1.ledLine == 8'h00 && waits < 10) begin
      tick();
      waits++;
    end
    chk("midrun_nonzero", 32'(bus1.ledLine != 8'h00), 32'h1);
    rst = 1'b1;
    #1;
    chk("async_reset_dut1", 32'(bus1.ledLine), 32'h00);
    chk("async_reset_dut4", 32'(bus4.ledLine), 32'h00);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      chk($sformatf("replay_c%0d", c), 32'(bus1.ledLine), 32'(rec[c]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
